// File: rtl/cubed_ddr_pkg.sv
// Shared DDR requestor definitions: bus widths and the fetch-engine state encoding.
// Imported by splat_fetch and its bus interface.
package cubed_ddr_pkg;

  localparam int unsigned DDR_ADDR_W  = 29;  // 64-bit word address
  localparam int unsigned DDR_DATA_W  = 64;
  localparam int unsigned DDR_BURST_W = 8;

  // Fetch-engine states, kept as plain constants for compatibility with older blocks.
  typedef logic [2:0] fetch_state_t;
  localparam fetch_state_t StIdle     = 3'd0;
  localparam fetch_state_t StWaitRoom = 3'd1;
  localparam fetch_state_t StReq      = 3'd2;
  localparam fetch_state_t StRecv     = 3'd3;
  localparam fetch_state_t StDrain    = 3'd4;

endpackage

// File: rtl/splat_fetch_if.sv
// Bus bundle for splat_fetch: DDR arbiter read port plus the valid/ready word stream.
//   master : the fetch engine (drives rd_addr/rd_burstcnt/rd_req and q_data/q_valid)
//   slave  : the arbiter + consumer side (drives rd_ack/rd_data/rd_data_valid and q_ready)
interface splat_fetch_if;
  import cubed_ddr_pkg::*;

  logic [DDR_ADDR_W-1:0]  rd_addr;
  logic [DDR_BURST_W-1:0] rd_burstcnt;
  logic                   rd_req;
  logic                   rd_ack;
  logic [DDR_DATA_W-1:0]  rd_data;
  logic                   rd_data_valid;
  logic [DDR_DATA_W-1:0]  q_data;
  logic                   q_valid;
  logic                   q_ready;

  modport master (
    output rd_addr, rd_burstcnt, rd_req, q_data, q_valid,
    input  rd_ack, rd_data, rd_data_valid, q_ready
  );

  modport slave (
    input  rd_addr, rd_burstcnt, rd_req, q_data, q_valid,
    output rd_ack, rd_data, rd_data_valid, q_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// Ports: clk, reset (sync, active-high), push_i/push_data_i, pop_i,
//        pop_data_o (head word), valid_o (not empty), count_o (occupancy).
// Depth must be a power of two >= 2. A push while full is accepted only if a pop
// happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [Width-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           pop_data_o,
  output logic                       valid_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CntW'(1);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign valid_o    = !empty;
  assign count_o    = count_q;
endmodule

// File: rtl/splat_fetch.sv
// Splat fetch engine: reads word_count 64-bit words from DDR starting at base_addr in
// bursts of at most MAX_BURST words and streams them to the core through a FIFO.
// Ports: clk, reset (sync, active-high), start/base_addr/word_count (job launch),
//        busy/done (job status), bus (splat_fetch_if.master: DDR read port + word stream).
// Optional build macro SPLAT_FETCH_STATS_EN adds stat_bursts (acked bursts) and
// stat_stall (cycles in WAIT_ROOM/REQ), both saturating and cleared on start/reset.
module splat_fetch
  import cubed_ddr_pkg::*;
#(
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DDR_ADDR_W-1:0] base_addr,
  input  logic [15:0]           word_count,
  output logic                  busy,
  output logic                  done,
`ifdef SPLAT_FETCH_STATS_EN
  output logic [15:0]           stat_bursts,
  output logic [15:0]           stat_stall,
`endif
  splat_fetch_if.master         bus
);
  localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t           state_q, state_d;
  logic [DDR_ADDR_W-1:0]  addr_q, addr_d;
  logic [15:0]            remain_q, remain_d;
  logic [DDR_BURST_W-1:0] blen_q, blen_d;
  logic [DDR_BURST_W-1:0] beats_q, beats_d;
  logic                   rd_req_q, rd_req_d;
  logic                   done_q, done_d;

  logic [DDR_BURST_W-1:0] blen_c;
  logic [15:0]            free_c;
  logic [OccW-1:0]        fifo_count;
  logic [DDR_DATA_W-1:0]  fifo_data;
  logic                   fifo_valid, push, pop;

  // Only RECV accepts data, so stray or post-reset beats never reach the FIFO.
  assign push   = (state_q == StRecv) && bus.rd_data_valid;
  assign pop    = fifo_valid && bus.q_ready;
  assign blen_c = (remain_q < 16'(MAX_BURST)) ? remain_q[DDR_BURST_W-1:0]
                                              : DDR_BURST_W'(MAX_BURST);
  // No push happens outside RECV, so free space seen in WAIT_ROOM can only grow:
  // reserving the whole burst up front guarantees the FIFO never overflows.
  assign free_c = 16'(FIFO_DEPTH) - 16'(fifo_count);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    blen_d   = blen_q;
    beats_d  = beats_q;
    rd_req_d = rd_req_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          addr_d   = base_addr;
          remain_d = word_count;
          if (word_count != 16'd0) state_d = StWaitRoom;
          else                     done_d  = 1'b1;
        end
      end
      StWaitRoom: begin
        if (free_c >= 16'(blen_c)) begin
          blen_d   = blen_c;
          rd_req_d = 1'b1;
          state_d  = StReq;
        end
      end
      StReq: begin
        if (bus.rd_ack) begin
          rd_req_d = 1'b0;
          addr_d   = addr_q + DDR_ADDR_W'(blen_q);  // wraps modulo 2^29
          remain_d = remain_q - 16'(blen_q);
          beats_d  = blen_q;
          state_d  = StRecv;
        end
      end
      StRecv: begin
        if (bus.rd_data_valid) begin
          beats_d = beats_q - DDR_BURST_W'(1);
          if (beats_q == DDR_BURST_W'(1)) begin
            state_d = (remain_q != 16'd0) ? StWaitRoom : StDrain;
          end
        end
      end
      StDrain: begin
        if (!fifo_valid) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      remain_q <= '0;
      blen_q   <= '0;
      beats_q  <= '0;
      rd_req_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      blen_q   <= blen_d;
      beats_q  <= beats_d;
      rd_req_q <= rd_req_d;
      done_q   <= done_d;
    end
  end

  sync_fifo #(
    .Width (DDR_DATA_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (bus.rd_data),
    .pop_i       (pop),
    .pop_data_o  (fifo_data),
    .valid_o     (fifo_valid),
    .count_o     (fifo_count)
  );

  assign busy            = (state_q != StIdle);
  assign done            = done_q;
  assign bus.rd_addr     = addr_q;
  assign bus.rd_burstcnt = blen_q;
  assign bus.rd_req      = rd_req_q;
  assign bus.q_data      = fifo_data;
  assign bus.q_valid     = fifo_valid;

`ifdef SPLAT_FETCH_STATS_EN
  logic [15:0] bursts_q, stall_q;
  logic        start_ok;

  assign start_ok = start && (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      bursts_q <= '0;
      stall_q  <= '0;
    end else begin
      if ((state_q == StReq) && bus.rd_ack && (bursts_q != 16'hFFFF)) begin
        bursts_q <= bursts_q + 16'd1;
      end
      if (((state_q == StWaitRoom) || (state_q == StReq)) && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign stat_bursts = bursts_q;
  assign stat_stall  = stall_q;
`endif
endmodule

// File: tb/tb_splat_fetch.sv
module tb_splat_fetch;
  import cubed_ddr_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [28:0] base_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
`ifdef SPLAT_FETCH_STATS_EN
  logic [15:0] stat_bursts;
  logic [15:0] stat_stall;
`endif

  splat_fetch_if bus ();

  splat_fetch #(
    .MAX_BURST  (8),
    .FIFO_DEPTH (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .word_count  (word_count),
    .busy        (busy),
    .done        (done),
`ifdef SPLAT_FETCH_STATS_EN
    .stat_bursts (stat_bursts),
    .stat_stall  (stat_stall),
`endif
    .bus         (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [28:0] a;
    logic [7:0]  n;
  } burst_t;

  typedef struct {
    logic [28:0] base;
    logic [15:0] count;
    int          ack_dly;
    int          rmode;        // 0 ready high, 1 random, 2 low
    bit          intrude;      // pulse a second start while busy
    int          exp_bursts;
    logic [7:0]  exp_last_len;
    logic [28:0] exp_end_addr;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  burst_t      burst_log[$];
  int          ack_delay  = 0;
  int          ready_mode = 0;   // 3 = pop exactly 'credit' words
  int          credit     = 0;
  int          done_cnt   = 0;
  int          beats_sent = 0;
  bit          resp_busy  = 1'b0;

  function automatic logic [63:0] data_of(input logic [28:0] a);
    return {a, 6'h2A, ~a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // DDR arbiter model: logs each request, acks after ack_delay cycles, returns the burst.
  initial begin : responder
    logic [28:0] a;
    logic [7:0]  n;
    burst_t      b;
    bus.rd_ack        = 1'b0;
    bus.rd_data_valid = 1'b0;
    bus.rd_data       = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.rd_req === 1'b1) begin
        resp_busy = 1'b1;
        a = bus.rd_addr;
        n = bus.rd_burstcnt;
        b.a = a;
        b.n = n;
        burst_log.push_back(b);
        for (int k = 0; k < ack_delay; k++) begin
          @(posedge clk); #1;
          check("rd_req held until ack", bus.rd_req, 1);
          check("rd_addr stable until ack", bus.rd_addr, a);
          check("rd_burstcnt stable until ack", bus.rd_burstcnt, n);
        end
        bus.rd_ack = 1'b1;
        @(posedge clk); #1;
        bus.rd_ack = 1'b0;
        check("rd_req low after ack", bus.rd_req, 0);
        for (int k = 0; k < int'(n); k++) begin
          bus.rd_data       = data_of(a + 29'(k));
          bus.rd_data_valid = 1'b1;
          @(posedge clk);
          beats_sent++;
          #1;
        end
        bus.rd_data_valid = 1'b0;
        bus.rd_data       = '0;
        resp_busy = 1'b0;
      end
    end
  end

  initial begin : ready_driver
    bus.q_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.q_ready = 1'b1;
        1:       bus.q_ready = 1'($urandom_range(0, 1));
        2:       bus.q_ready = 1'b0;
        default: bus.q_ready = (credit > 0);
      endcase
    end
  end

  // Scoreboard consumer and done monitor.
  initial begin : consumer
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && bus.q_valid === 1'b1 && bus.q_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected word: got 0x%0h, expected none", bus.q_data);
        end else begin
          e = exp_q.pop_front();
          check("q_data", bus.q_data, e);
        end
        if (credit > 0) credit--;
      end
      if (done === 1'b1) begin
        done_cnt++;
        check("busy low with done", busy, 0);
      end
    end
  end

  task automatic wait_done(input string name);
    int t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(name, (done_cnt != 0), 1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [28:0] ma;
    logic [15:0] mrem;
    logic [7:0]  mlen;
    int          t;
    burst_log.delete();
    done_cnt   = 0;
    ack_delay  = v.ack_dly;
    ready_mode = v.rmode;
    for (int i = 0; i < int'(v.count); i++) exp_q.push_back(data_of(v.base + 29'(i)));
    @(posedge clk); #1;
    start = 1'b1; base_addr = v.base; word_count = v.count;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy after start", busy, 1);
    if (v.intrude) begin
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; base_addr = 29'h900; word_count = 16'd3;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done("done before timeout");
    repeat (5) @(negedge clk);
    check("single done pulse", done_cnt, 1);
    check("all words delivered", exp_q.size(), 0);
    check("rd_req idle", bus.rd_req, 0);
    check("final rd_addr", bus.rd_addr, v.exp_end_addr);
    check("final rd_burstcnt", bus.rd_burstcnt, v.exp_last_len);
    check("burst count", burst_log.size(), v.exp_bursts);
    ma   = v.base;
    mrem = v.count;
    foreach (burst_log[i]) begin
      mlen = (mrem < 16'd8) ? mrem[7:0] : 8'd8;
      check("burst addr", burst_log[i].a, ma);
      check("burst len", burst_log[i].n, mlen);
      ma   = ma + 29'(mlen);
      mrem = mrem - 16'(mlen);
    end
    t = 0;
    while (resp_busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    exp_q.delete();
  endtask

  initial begin : main
    vec_t vecs[6];
    bit   bad;
    int   t;
    vecs[0] = '{29'h100,      16'd20, 2, 0, 1'b0, 3, 8'd4, 29'h114};
    vecs[1] = '{29'h1FFFFFFC, 16'd8,  1, 0, 1'b0, 1, 8'd8, 29'h4};
    vecs[2] = '{29'h2000,     16'd1,  0, 1, 1'b0, 1, 8'd1, 29'h2001};
    vecs[3] = '{29'h55,       16'd17, 3, 1, 1'b0, 3, 8'd1, 29'h66};
    vecs[4] = '{29'h500,      16'd12, 1, 0, 1'b1, 2, 8'd4, 29'h50C};
    vecs[5] = '{29'h1FFFFFF0, 16'd24, 0, 1, 1'b0, 3, 8'd8, 29'h8};

    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset rd_req", bus.rd_req, 0);
    check("reset q_valid", bus.q_valid, 0);
    check("reset rd_addr", bus.rd_addr, 0);
    check("reset rd_burstcnt", bus.rd_burstcnt, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Zero-length job: done next cycle, never busy, no request.
    done_cnt = 0; burst_log.delete(); ready_mode = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 29'h700; word_count = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero-count done pulse", done, 1);
    check("zero-count busy", busy, 0);
    @(negedge clk);
    check("zero-count done width", done, 0);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0 || bus.rd_req !== 1'b0) bad = 1'b1;
    end
    check("zero-count no busy/req", bad, 0);
    check("zero-count no bursts", burst_log.size(), 0);
    check("zero-count done count", done_cnt, 1);

    // Backpressure: FIFO fills after two bursts; third waits for 4 free entries.
    done_cnt = 0; burst_log.delete(); ready_mode = 2; credit = 0; ack_delay = 1;
    for (int i = 0; i < 20; i++) exp_q.push_back(data_of(29'h300 + 29'(i)));
    @(posedge clk); #1;
    start = 1'b1; base_addr = 29'h300; word_count = 16'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (150) @(negedge clk);
    check("stalled: two bursts", burst_log.size(), 2);
    check("stalled: fifo holds data", bus.q_valid, 1);
    credit = 3; ready_mode = 3;
    repeat (30) @(negedge clk);
    check("3 free: no third burst", burst_log.size(), 2);
    credit = 1;
    repeat (30) @(negedge clk);
    check("4 free: third burst", burst_log.size(), 3);
    if (burst_log.size() == 3) begin
      check("third burst addr", burst_log[2].a, 29'h310);
      check("third burst len", burst_log[2].n, 8'd4);
    end
    ready_mode = 0;
    wait_done("backpressure done");
    repeat (3) @(negedge clk);
    check("backpressure words", exp_q.size(), 0);
    check("backpressure done count", done_cnt, 1);
    t = 0;
    while (resp_busy && t < 100) begin @(negedge clk); t++; end

    // Reset three words into an 8-word burst; trailing beats must be dropped.
    done_cnt = 0; burst_log.delete(); ready_mode = 2; ack_delay = 1; beats_sent = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 29'h400; word_count = 16'd8;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (beats_sent < 3 && t < 200) begin @(negedge clk); t++; end
    check("three beats reached", beats_sent, 3);
    check("fifo holds beats", bus.q_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check("reset-mid rd_req", bus.rd_req, 0);
    check("reset-mid q_valid", bus.q_valid, 0);
    check("reset-mid busy", busy, 0);
    reset = 1'b0;
    bad = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.q_valid !== 1'b0 || busy !== 1'b0 || bus.rd_req !== 1'b0) bad = 1'b1;
    end
    check("trailing beats ignored", bad, 0);
    check("reset-mid no done", done_cnt, 0);
    exp_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/splat_fetch.md
SPLAT_FETCH -- requirements
Module: splat_fetch

Interface
REQ-001 SHALL have parameter MAX_BURST, default 8, maximum words per DDR read burst (1..128).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, output FIFO entries (power of 2, >= MAX_BURST).
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle pulse; latches base_addr and word_count.
REQ-006 SHALL have port base_addr  in  29  first 64-bit word address.
REQ-007 SHALL have port word_count  in  16  words to fetch.
REQ-008 SHALL have port busy  out  1  high from accepted start until done.
REQ-009 SHALL have port done  out  1  one-cycle pulse at completion.
REQ-010 SHALL have ports rd_addr out 29, rd_burstcnt out 8, rd_req out 1, rd_ack in 1, rd_data in 64, rd_data_valid in 1  DDR arbiter requestor read port.
REQ-011 SHALL have ports q_data out 64, q_valid out 1, q_ready in 1  valid/ready word stream to the core.

Function
- REQ-012 SHALL implement states IDLE, WAIT_ROOM, REQ, RECV, DRAIN.
- REQ-013 IDLE: start with word_count>0 -> WAIT_ROOM, busy=1; start with word_count==0 -> done pulse next cycle, stay IDLE.
- REQ-014 start while busy SHALL be ignored.
- REQ-015 Burst length blen = min(MAX_BURST, remaining words), computed in WAIT_ROOM.
- REQ-016 WAIT_ROOM -> REQ when FIFO free entries (FIFO_DEPTH - occupancy) >= blen; otherwise hold.
- REQ-017 REQ: rd_req=1 with rd_addr=current address, rd_burstcnt=blen, both stable until rd_ack.
- REQ-018 On the rd_ack cycle: rd_req registered low next cycle, address += blen, remaining -= blen, -> RECV.
- REQ-019 RECV: each rd_data_valid pushes rd_data into FIFO, decrements burst counter; last word -> WAIT_ROOM if remaining>0, else DRAIN.
- REQ-020 rd_data_valid outside RECV SHALL be ignored (no push).
- REQ-021 Only one burst outstanding at a time; reservation SHALL guarantee no push when full.
- REQ-022 DRAIN: when FIFO empty -> IDLE, done=1 for one cycle, busy=0 same cycle.
- REQ-023 FIFO: first-word-fall-through, q_valid = not empty; pop on q_valid&&q_ready; simultaneous push and pop at full/empty SHALL keep occupancy consistent.
- REQ-024 Pushed word SHALL appear on q_data no earlier than the cycle after its rd_data_valid.
- REQ-025 Address arithmetic SHALL wrap modulo 2^29.

Reset
- REQ-026 Reset SHALL force IDLE, busy=0, done=0, rd_req=0, FIFO empty (q_valid=0), counters 0; rd_addr/rd_burstcnt 0.
- REQ-027 Reset mid-burst SHALL abandon the burst; later rd_data_valid ignored.

Configuration
- REQ-028 Macro SPLAT_FETCH_STATS_EN defined: add ports stat_bursts out 16 (saturating count of rd_ack) and stat_stall out 16 (saturating count of cycles in WAIT_ROOM or REQ); both clear on start and reset.
- REQ-029 Macro undefined: ports and counters absent; behaviour otherwise identical.

Structure
- REQ-030 DDR_ADDR_W=29, DDR_DATA_W=64, DDR_BURST_W=8 and the state enum SHALL live in shared package cubed_ddr_pkg.
- REQ-031 FIFO SHALL be sub-module sync_fifo (parameterised width/depth, occupancy output).

Verification
- REQ-032 base=0x100, count=20, q_ready=1, ack after 2 cycles -> bursts (0x100,8),(0x108,8),(0x110,4); 20 words in order; one done.
- REQ-033 count=20, q_ready=0 -> two 8-word bursts, third burst not requested until ≥4 words popped.
- REQ-034 count=0 -> no rd_req, done one cycle after start, busy never high.
- REQ-035 reset asserted mid-RECV of 8-word burst, 3 words in -> rd_req=0, q_valid=0 next cycle; trailing valids not queued.
- REQ-036 start pulsed during busy with different base -> ignored; original stream completes unchanged.
- REQ-037 base=0x1FFFFFFC, count=8 -> bursts at 0x1FFFFFFC; addr wraps to 0x00000004 after.
